// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction store with a combinational fetch port and a
// byte-serial program loader. Incoming bytes are packed big-endian into
// 32-bit words, and each word is written the same cycle its 4th byte arrives.
// Optional feature: define INST_ROM_CKSUM_EN to add load_cksum_o, the
// modulo-2^32 sum of the words written by the current load.
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    input  logic                  load_start_i,
    input  logic [DEPTH_LOG2:0]   load_len_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_byte_i,
    output logic                  load_ready_o,
    output logic                  load_busy_o,
    output logic                  load_done_o,
`ifdef INST_ROM_CKSUM_EN
    output logic                  load_err_o,
    output logic [31:0]           load_cksum_o
`else
    output logic                  load_err_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] MAX_LEN = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2:0]   ptr_reg,   ptr_next;
    logic [DEPTH_LOG2:0]   len_reg,   len_next;
    logic [1:0]            cnt_reg,   cnt_next;
    logic [23:0]           asm_reg,   asm_next;
    logic                  done_reg,  done_next;
    logic                  err_reg,   err_next;

    logic                  wr_en;
    logic [31:0]           wr_data;
    logic                  len_over;
    logic [DEPTH_LOG2:0]   start_len;
    logic                  last_word;
    logic                  addr_ok;
    logic                  unused_addr_bits;

    logic [31:0]           mem [DEPTH];

    // Over-long requests are clamped to the full store and flagged.
    assign len_over  = (load_len_i > MAX_LEN);
    assign start_len = len_over ? MAX_LEN : load_len_i;
    assign last_word = ((ptr_reg + 1'b1) == len_reg);

    // Next-state, assembly and write-strobe logic for the loader FSM.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        asm_next   = asm_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        wr_en      = 1'b0;
        wr_data    = {asm_reg, load_byte_i};
        case (state_reg)
            IDLE: begin
                if (load_start_i) begin
                    len_next = start_len;
                    err_next = len_over;
                    ptr_next = '0;
                    cnt_next = '0;
                    asm_next = '0;
                    if (start_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (load_valid_i) begin
                    cnt_next = cnt_reg + 2'd1;
                    asm_next = {asm_reg[15:0], load_byte_i};
                    if (cnt_reg == 2'd3) begin
                        wr_en    = 1'b1;
                        ptr_next = ptr_reg + 1'b1;
                        if (last_word) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Loader state register; reset abandons any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            asm_reg   <= asm_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Instruction store write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr_reg[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

`ifdef INST_ROM_CKSUM_EN
    logic [31:0] cksum_reg;

    // Running sum of words written since the last accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_reg <= '0;
        end else if (state_reg == IDLE && load_start_i) begin
            cksum_reg <= '0;
        end else if (wr_en) begin
            cksum_reg <= cksum_reg + wr_data;
        end
    end

    assign load_cksum_o = cksum_reg;
`endif

    // Fetch returns a NOP while loading, in reset, or outside the store.
    assign addr_ok          = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
    assign unused_addr_bits = &{1'b0, rom_addr_i[1:0]};
    assign rom_data_o       = (rom_ce_i && !load_busy_o && !rst && addr_ok)
                              ? mem[rom_addr_i[DEPTH_LOG2+1:2]] : 32'h0;

    assign load_busy_o  = (state_reg == RECV);
    assign load_ready_o = (state_reg == RECV);
    assign load_done_o  = done_reg;
    assign load_err_o   = err_reg;

endmodule
